// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its consumers.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
package imem_pkg;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 16;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef logic [DATA_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0] iaddr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE
  } loader_state_t;

  // State entered once the last payload byte of a frame has been taken.
  function automatic loader_state_t frame_end_state();
`ifdef IMEM_LOADER_CHECKSUM_EN
    return S_CSUM;
`else
    return S_DONE;
`endif
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if;
  import imem_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  iaddr_t     mem_addr;
  instr_t     mem_wdata;
  logic       cpu_stall;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_stall, busy, done, err
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_stall, busy, done, err
  );

endinterface

// File: rtl/imem_loader_byte_pair_assembler.sv
// Joins a big-endian byte pair into one 16-bit word; shared by the address,
// count and data fields since they never overlap in time.
module byte_pair_assembler
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_i,
  input  logic       hi_en_i,
  input  logic       lo_en_i,
  output instr_t     word_o,
  output logic       valid_o
);

  logic [7:0] hi_q;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
    end else if (hi_en_i) begin
      hi_q <= byte_i;
    end
  end

  assign word_o  = {hi_q, byte_i};
  assign valid_o = lo_en_i;

endmodule

// File: rtl/imem_loader.sv
// Loads framed program images (SYNC, ADDR, CNT, words) into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  loader_state_t state_q, state_d;
  iaddr_t        addr_q, addr_d;
  instr_t        cnt_q, cnt_d;
  logic          mem_we_q, mem_we_d;
  iaddr_t        mem_addr_q, mem_addr_d;
  instr_t        mem_wdata_q, mem_wdata_d;
  logic          accept, hi_en, lo_en, pair_valid;
  instr_t        pair_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          err_q, err_d;
`endif

  assign accept = bus.rx_valid && bus.rx_ready;
  assign hi_en  = accept && (state_q inside {S_ADDR_HI, S_CNT_HI, S_DATA_HI});
  assign lo_en  = accept && (state_q inside {S_ADDR_LO, S_CNT_LO, S_DATA_LO});

  byte_pair_assembler u_pair (
    .clk     (clk),
    .reset   (reset),
    .byte_i  (bus.rx_data),
    .hi_en_i (hi_en),
    .lo_en_i (lo_en),
    .word_o  (pair_word),
    .valid_o (pair_valid)
  );

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE:    if (accept && bus.rx_data == SYNC_BYTE) state_d = S_ADDR_HI;
      S_ADDR_HI: if (accept) state_d = S_ADDR_LO;
      S_ADDR_LO: if (pair_valid) begin
        addr_d  = pair_word;
        state_d = S_CNT_HI;
      end
      S_CNT_HI:  if (accept) state_d = S_CNT_LO;
      S_CNT_LO:  if (pair_valid) begin
        cnt_d   = pair_word;
        state_d = (pair_word == '0) ? frame_end_state() : S_DATA_HI;
      end
      S_DATA_HI: if (accept) state_d = S_DATA_LO;
      S_DATA_LO: if (pair_valid) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = pair_word;
        addr_d      = addr_q + 1'b1;
        cnt_d       = cnt_q - 1'b1;
        state_d     = (cnt_q == instr_t'(1)) ? frame_end_state() : S_DATA_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:    if (accept) begin
        if (bus.rx_data != csum_q) err_d = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    // The XOR covers every byte after SYNC up to, but not including, the checksum itself.
    if (accept) begin
      if (state_q == S_IDLE)      csum_d = '0;
      else if (state_q != S_CSUM) csum_d = csum_q ^ bus.rx_data;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rx_ready  = (state_q != S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cpu_stall = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum cases run only
// when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  imem_loader_if bus();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    iaddr_t addr;
    instr_t data;
  } wr_t;

  wr_t        wr_log[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] run_xor  = '0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t w;
    if (bus.mem_we === 1'b1) begin
      w.addr = bus.mem_addr;
      w.data = bus.mem_wdata;
      wr_log.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && guard < 8) begin
      idle_cycle();
      guard++;
    end
    if (guard == 8) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    idle_cycle();
    bus.rx_valid = 1'b0;
    run_xor ^= b;
  endtask

  task automatic send_header(input logic [15:0] addr, input logic [15:0] cnt);
    send_byte(SYNC_BYTE);
    run_xor = '0;
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(run_xor);
`endif
  endtask

  task automatic check_write(input string tag, input int idx, input logic [15:0] addr,
                             input logic [15:0] data);
    if (wr_log.size() > idx) begin
      check({tag, "_addr"}, 32'(wr_log[idx].addr), 32'(addr));
      check({tag, "_data"}, 32'(wr_log[idx].data), 32'(data));
    end else begin
      check({tag, "_missing"}, 32'(wr_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd1);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_cpu_stall"}, 32'(bus.cpu_stall), 32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  initial begin
    logic [7:0] garbage [3];
    garbage[0] = 8'h00;
    garbage[1] = 8'hFF;
    garbage[2] = 8'h13;

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    idle_cycle();
    idle_cycle();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single word at 0x000C.
    wr_log.delete();
    send_byte(SYNC_BYTE);
    run_xor = '0;
    check("a_stall_after_sync", 32'(bus.cpu_stall), 32'd1);
    check("a_busy_after_sync",  32'(bus.busy),      32'd1);
    send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h01);
    send_word(16'h5081);
    send_trailer();
    check("a_done",          32'(bus.done),      32'd1);
    check("a_stall_in_done", 32'(bus.cpu_stall), 32'd1);
    check("a_ready_in_done", 32'(bus.rx_ready),  32'd0);
    idle_cycle();
    check("a_done_cleared",  32'(bus.done),      32'd0);
    check("a_stall_cleared", 32'(bus.cpu_stall), 32'd0);
    check("a_busy_cleared",  32'(bus.busy),      32'd0);
    check("a_addr_hold",     32'(bus.mem_addr),  32'h000C);
    check("a_wdata_hold",    32'(bus.mem_wdata), 32'h5081);
    check("a_nwrites",       32'(wr_log.size()), 32'd1);
    check_write("a_w0", 0, 16'h000C, 16'h5081);

    // Address wrap-around.
    wr_log.delete();
    send_header(16'hFFFF, 16'd3);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_trailer();
    idle_cycle();
    check("wrap_nwrites", 32'(wr_log.size()), 32'd3);
    check_write("wrap_w0", 0, 16'hFFFF, 16'h1111);
    check_write("wrap_w1", 1, 16'h0000, 16'h2222);
    check_write("wrap_w2", 2, 16'h0001, 16'h3333);

    // Zero-length frame.
    wr_log.delete();
    send_header(16'h0020, 16'd0);
    send_trailer();
    check("zero_done", 32'(bus.done), 32'd1);
    idle_cycle();
    check("zero_done_cleared", 32'(bus.done),      32'd0);
    check("zero_nwrites",      32'(wr_log.size()), 32'd0);

    // Leading garbage, a stalled source mid-word, and SYNC as payload.
    wr_log.delete();
    foreach (garbage[i]) begin
      send_byte(garbage[i]);
      check($sformatf("garbage%0d_busy", i), 32'(bus.busy), 32'd0);
    end
    send_header(16'h0040, 16'd2);
    send_byte(8'hAA);
    idle_cycle();
    idle_cycle();
    check("gap_stall_held", 32'(bus.cpu_stall), 32'd1);
    send_byte(8'hBB);
    send_word(16'hA5A5);
    send_trailer();
    idle_cycle();
    check("gap_nwrites", 32'(wr_log.size()), 32'd2);
    check_write("gap_w0", 0, 16'h0040, 16'hAABB);
    check_write("gap_w1", 1, 16'h0041, 16'hA5A5);

    // Reset in the middle of a five-word frame.
    wr_log.delete();
    send_header(16'h0010, 16'd5);
    send_word(16'h1000);
    send_word(16'h1001);
    send_word(16'h1002);
    send_byte(8'h10);
    bus.rx_data  = 8'h03;
    bus.rx_valid = 1'b1;
    reset        = 1'b1;
    idle_cycle();
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_outputs("midreset");
    idle_cycle();
    idle_cycle();
    check("midreset_nwrites", 32'(wr_log.size()), 32'd3);
    check_write("midreset_w0", 0, 16'h0010, 16'h1000);
    check_write("midreset_w1", 1, 16'h0011, 16'h1001);
    check_write("midreset_w2", 2, 16'h0012, 16'h1002);
    wr_log.delete();
    send_header(16'h0050, 16'd1);
    send_word(16'h1234);
    send_trailer();
    idle_cycle();
    check("reload_nwrites", 32'(wr_log.size()), 32'd1);
    check_write("reload_w0", 0, 16'h0050, 16'h1234);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum: XOR(00 60 00 01 DE AD) = 12.
    send_header(16'h0060, 16'd1);
    send_word(16'hDEAD);
    check("csum_expected_value", 32'(run_xor), 32'h12);
    send_trailer();
    check("csum_good_done", 32'(bus.done), 32'd1);
    check("csum_good_err",  32'(bus.err),  32'd0);
    idle_cycle();

    // Bad checksum sets err, which survives the next good frame.
    send_header(16'h0061, 16'd1);
    send_word(16'h0001);
    send_byte(~run_xor);
    check("csum_bad_done", 32'(bus.done), 32'd1);
    check("csum_bad_err",  32'(bus.err),  32'd1);
    idle_cycle();
    send_header(16'h0062, 16'd1);
    send_word(16'h0002);
    send_trailer();
    idle_cycle();
    check("csum_err_sticky", 32'(bus.err), 32'd1);
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    check("csum_err_reset", 32'(bus.err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
